uart_tx_frame: RTL

- Serial transmit framer. Sits directly downstream of the baud clock generator and drives that generator's count-enable input.
- Accepts one parallel byte through a valid/ready handshake.
- Starts the baud generator, then shifts out start, data, optional parity and stop bits on txd. Each transition happens on one bpsClk pulse.
- Output feeds the board TX pin.

---
 rtl/uart_tx_frame.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// uart_tx_frame: serial transmit framer driven by an external baud pulse.
// Accepts one parallel word per valid/ready handshake. It enables the baud
// generator, then shifts out start, data (LSB first), optional parity and
// stop bits on txd, advancing one bit per bpsClk pulse.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   txData       - word to send, sampled on accept
//   txValid      - txData valid; accept = txValid & txReady at a clk edge
//   txReady      - framer idle and able to accept
//   bpsClk       - one-cycle baud pulse from the generator
//   countEnable  - enables the baud generator counter for the whole frame
//   txd          - serial line, idle high
//   busy         - frame in progress (inverse of txReady)
//   txDone       - one-cycle pulse when a frame completes
module uart_tx_frame #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txValid,
  output logic                 txReady,
  input  logic                 bpsClk,
  output logic                 countEnable,
  output logic                 txd,
  output logic                 busy,
  output logic                 txDone
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE, ARM, START, DATA, PARITY, STOP
  } state_t;

  state_t                 state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [1:0]             stop_cnt_q;
  logic                   parity_q;
  logic                   txd_q;
  logic                   ce_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   accept_c;

  assign accept_c = txValid & ready_q & (state_q == IDLE);

  // Framer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      ce_q       <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      // Ready follows IDLE one cycle late, so it stays low in the txDone cycle
      // and drops on the accept edge itself.
      ready_q <= (state_q == IDLE) && !accept_c;
      busy_q  <= !((state_q == IDLE) && !accept_c);

      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          ce_q  <= 1'b0;
          if (accept_c) begin
            shift_q   <= txData;
            parity_q  <= (^txData) ^ (PARITY_ODD != 0);
            bit_cnt_q <= '0;
            ce_q      <= 1'b1;
            state_q   <= ARM;
          end
        end
        // Absorbs the generator's half-period lead-in before the start bit
        ARM: begin
          if (bpsClk) begin
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bpsClk) begin
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= CNT_W'(1);
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bpsClk) begin
            if (bit_cnt_q < CNT_W'(DATA_BITS)) begin
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else if (PARITY_EN != 0) begin
              txd_q   <= parity_q;
              state_q <= PARITY;
            end else begin
              txd_q      <= 1'b1;
              stop_cnt_q <= 2'd1;
              state_q    <= STOP;
            end
          end
        end
        PARITY: begin
          if (bpsClk) begin
            txd_q      <= 1'b1;
            stop_cnt_q <= 2'd1;
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (bpsClk) begin
            if (stop_cnt_q < 2'(STOP_BITS)) begin
              stop_cnt_q <= stop_cnt_q + 2'd1;
            end else begin
              ce_q      <= 1'b0;
              done_q    <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txReady     = ready_q;
  assign busy        = busy_q;
  assign countEnable = ce_q;
  assign txd         = txd_q;
  assign txDone      = done_q;

endmodule
